// File: rtl/user_logic_signal_processing_pkg.sv
// Shared constants and types for the ADQ214 user-logic DSP slot.
package user_logic_signal_processing_pkg;

  // Accumulator width and part-number defaults identifying this build.
  localparam int          DEF_ACC_W       = 32;
  localparam logic [15:0] DEF_PARTNUM_1   = 16'h4C44;
  localparam logic [15:0] DEF_PARTNUM_2   = 16'h5350;
  localparam logic [15:0] DEF_PARTNUM_3   = 16'h0001;
  localparam logic [15:0] DEF_PARTNUM_REV = 16'h0100;

  // Field layout of the 64-bit status word on user_register_o.
  localparam int SUM_LSB = 0;
  localparam int SUM_W   = 32;
  localparam int CNT_LSB = 32;
  localparam int CNT_W   = 16;
  localparam int LEN_LSB = 48;
  localparam int LEN_W   = 16;

  // Range-gate window state.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } gate_state_e;

endpackage

// File: rtl/user_logic_signal_processing_if.sv
// Sample, trigger and user-register bus between the digitizer datapath and
// the user-logic slot. The slot itself uses the slave view.
interface user_logic_signal_processing_if;

  logic [15:0]  x0_i;
  logic [15:0]  x0z_i;
  logic [15:0]  x1_i;
  logic [15:0]  x1z_i;
  logic [3:0]   trigger_vector_i;
  logic [127:0] user_register_i;

  logic [15:0]  y0_o;
  logic [15:0]  y0z_o;
  logic [15:0]  y1_o;
  logic [15:0]  y1z_o;
  logic [3:0]   trigger_vector_o;
  logic [63:0]  user_register_o;

  modport master (
    output x0_i, x0z_i, x1_i, x1z_i, trigger_vector_i, user_register_i,
    input  y0_o, y0z_o, y1_o, y1z_o, trigger_vector_o, user_register_o
  );

  modport slave (
    input  x0_i, x0z_i, x1_i, x1z_i, trigger_vector_i, user_register_i,
    output y0_o, y0z_o, y1_o, y1z_o, trigger_vector_o, user_register_o
  );

endinterface

// File: rtl/user_logic_signal_processing_range_gate_accumulator.sv
// Channel-0 range gate: trigger edge detect, window counter FSM, gated
// sample output, signed window accumulator and latched status word.
module user_logic_signal_processing_range_gate_accumulator
  import user_logic_signal_processing_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] x0_i,
  input  logic [15:0] x0z_i,
  input  logic [3:0]  trig_vec_i,
  input  logic [15:0] len_i,
  output logic [15:0] y0_o,
  output logic [15:0] y0z_o,
  output logic [63:0] status_o
);

  gate_state_e              state_q, state_d;
  logic [3:0]               trig_prev_q, trig_prev_d;
  logic [15:0]              cnt_q, cnt_d;
  logic [15:0]              len_q, len_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [15:0]              y0_q, y0_d;
  logic [15:0]              y0z_q, y0z_d;
  logic [SUM_W-1:0]         sum_q, sum_d;
  logic [CNT_W-1:0]         win_cnt_q, win_cnt_d;
  logic [LEN_W-1:0]         stat_len_q, stat_len_d;

  logic                     trig;
  logic                     win_edge;
  logic                     win_first;
  logic                     win_last;
  logic signed [ACC_W-1:0]  pair;
  logic signed [ACC_W-1:0]  acc_next;

  // Rising edge on any trigger line; a held line fires only once.
  assign trig = |(trig_vec_i & ~trig_prev_q);

  // Sign-extended sum of the current even/odd sample pair.
  assign pair = ACC_W'(signed'(x0_i)) + ACC_W'(signed'(x0z_i));

  // Next-state: window FSM, gating, accumulation and status latch.
  always_comb begin
    // NOTE: every _d takes its _q (or zero) first, so no branch leaves it
    // unassigned and no latch is inferred.
    state_d     = state_q;
    trig_prev_d = trig_vec_i;
    cnt_d       = cnt_q;
    len_d       = len_q;
    acc_d       = acc_q;
    y0_d        = '0;
    y0z_d       = '0;
    sum_d       = sum_q;
    win_cnt_d   = win_cnt_q;
    stat_len_d  = stat_len_q;
    win_edge    = 1'b0;
    win_first   = 1'b0;
    win_last    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // L == 0 disables the gate entirely.
        if (trig && (len_i != '0)) begin
          win_edge  = 1'b1;
          win_first = 1'b1;
          len_d     = len_i;
          cnt_d     = len_i - 16'd1;
          // A one-cycle window completes on the trigger edge itself.
          if (len_i == 16'd1) win_last = 1'b1;
          else                state_d  = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        // Triggers are ignored here; cnt holds the samples still to take.
        win_edge = 1'b1;
        cnt_d    = cnt_q - 16'd1;
        if (cnt_q == 16'd1) begin
          win_last = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    acc_next = win_first ? pair : acc_q + pair;

    if (win_edge) begin
      y0_d  = x0_i;
      y0z_d = x0z_i;
      acc_d = acc_next;
    end

    if (win_last) begin
      sum_d      = SUM_W'(acc_next);
      win_cnt_d  = win_cnt_q + CNT_W'(1);
      stat_len_d = len_d;
    end
  end

  // State register; synchronous reset aborts any open window silently.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      state_q     <= ST_IDLE;
      trig_prev_q <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      acc_q       <= '0;
      y0_q        <= '0;
      y0z_q       <= '0;
      sum_q       <= '0;
      win_cnt_q   <= '0;
      stat_len_q  <= '0;
    end else begin
      state_q     <= state_d;
      trig_prev_q <= trig_prev_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      acc_q       <= acc_d;
      y0_q        <= y0_d;
      y0z_q       <= y0z_d;
      sum_q       <= sum_d;
      win_cnt_q   <= win_cnt_d;
      stat_len_q  <= stat_len_d;
    end
  end

  // Assemble the status word from the latched fields.
  always_comb begin
    status_o                     = '0;
    status_o[SUM_LSB +: SUM_W]   = sum_q;
    status_o[CNT_LSB +: CNT_W]   = win_cnt_q;
    status_o[LEN_LSB +: LEN_W]   = stat_len_q;
  end

  assign y0_o  = y0_q;
  assign y0z_o = y0z_q;

endmodule

// File: rtl/user_logic_signal_processing.sv
// ADQ214 user-logic DSP slot: channel-0 range gate with window accumulator,
// registered channel-1 and trigger pass-through, constant part numbers.
module user_logic_signal_processing
  import user_logic_signal_processing_pkg::*;
#(
  parameter int          ACC_W       = DEF_ACC_W,
  parameter logic [15:0] PARTNUM_1   = DEF_PARTNUM_1,
  parameter logic [15:0] PARTNUM_2   = DEF_PARTNUM_2,
  parameter logic [15:0] PARTNUM_3   = DEF_PARTNUM_3,
  parameter logic [15:0] PARTNUM_REV = DEF_PARTNUM_REV
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  user_logic_signal_processing_if.slave  bus,
  output logic [15:0]                    ul_partnum_1_o,
  output logic [15:0]                    ul_partnum_2_o,
  output logic [15:0]                    ul_partnum_3_o,
  output logic [15:0]                    ul_partnum_rev_o
);

  logic [15:0] y1_q, y1_d;
  logic [15:0] y1z_q, y1z_d;
  logic [3:0]  trig_q, trig_d;

  // Only the window length field of the control word is used.
  logic unused_ctrl;
  assign unused_ctrl = ^bus.user_register_i[127:16];

  user_logic_signal_processing_range_gate_accumulator #(
    .ACC_W (ACC_W)
  ) u_range_gate_accumulator (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .x0_i       (bus.x0_i),
    .x0z_i      (bus.x0z_i),
    .trig_vec_i (bus.trigger_vector_i),
    .len_i      (bus.user_register_i[15:0]),
    .y0_o       (bus.y0_o),
    .y0z_o      (bus.y0z_o),
    .status_o   (bus.user_register_o)
  );

  // Pass-through next values: channel 1 and trigger lines, unmodified.
  always_comb begin
    y1_d   = bus.x1_i;
    y1z_d  = bus.x1z_i;
    trig_d = bus.trigger_vector_i;
  end

  // One-clock pass-through registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      y1_q   <= '0;
      y1z_q  <= '0;
      trig_q <= '0;
    end else begin
      y1_q   <= y1_d;
      y1z_q  <= y1z_d;
      trig_q <= trig_d;
    end
  end

  assign bus.y1_o             = y1_q;
  assign bus.y1z_o            = y1z_q;
  assign bus.trigger_vector_o = trig_q;

  assign ul_partnum_1_o   = PARTNUM_1;
  assign ul_partnum_2_o   = PARTNUM_2;
  assign ul_partnum_3_o   = PARTNUM_3;
  assign ul_partnum_rev_o = PARTNUM_REV;

endmodule

// File: tb/tb_user_logic_signal_processing.sv
// Directed bench for the user-logic DSP slot with hand-computed expectations.
module tb_user_logic_signal_processing;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] ul_partnum_1_o, ul_partnum_2_o, ul_partnum_3_o, ul_partnum_rev_o;

  int n_checks = 0;
  int n_pass   = 0;

  user_logic_signal_processing_if bus ();

  user_logic_signal_processing dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .bus              (bus),
    .ul_partnum_1_o   (ul_partnum_1_o),
    .ul_partnum_2_o   (ul_partnum_2_o),
    .ul_partnum_3_o   (ul_partnum_3_o),
    .ul_partnum_rev_o (ul_partnum_rev_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance one rising edge and settle past it.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [63:0] st(input int len, input int cnt, input int sum);
    return {16'(len), 16'(cnt), 32'(sum)};
  endfunction

  task automatic set_len(input logic [15:0] len);
    bus.user_register_i = {{7{16'hBEEF}}, len};
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          hits;
    logic [15:0] ra, rb;
    logic [3:0]  rt;

    rst_i                = 1'b1;
    bus.x0_i             = '0;
    bus.x0z_i            = '0;
    bus.x1_i             = 16'h1111;
    bus.x1z_i            = 16'h2222;
    bus.trigger_vector_i = '0;
    set_len(16'd0);
    step();
    step();

    // Reset state.
    check("rst_y0",     64'({bus.y0_o, bus.y0z_o}), 64'h0);
    check("rst_status", bus.user_register_o, 64'h0);
    check("rst_y1",     64'({bus.y1_o, bus.y1z_o, bus.trigger_vector_o}), 64'h0);
    check("partnum",    {ul_partnum_1_o, ul_partnum_2_o, ul_partnum_3_o, ul_partnum_rev_o},
          64'h4C44_5350_0001_0100);
    rst_i = 1'b0;
    step();

    // Window A: L=16, 100 + -20 per pair; a bit2 pulse on cycle 5 is ignored.
    set_len(16'd16);
    bus.x0_i             = 16'd100;
    bus.x0z_i            = 16'hFFEC;
    bus.trigger_vector_i = 4'b0001;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 1) bus.trigger_vector_i = 4'b0000;
      if (i == 4) bus.trigger_vector_i = 4'b0100;
      if (i == 5) bus.trigger_vector_i = 4'b0000;
      check($sformatf("winA_y0_%0d", i), 64'({bus.y0_o, bus.y0z_o}), 64'h0064_FFEC);
    end
    check("winA_status", bus.user_register_o, st(16, 1, 1280));
    step();
    check("winA_after_y0",     64'({bus.y0_o, bus.y0z_o}), 64'h0);
    check("winA_after_status", bus.user_register_o, st(16, 1, 1280));

    // Window C: bit3, L=4 of (-3 + 7); L changed mid-window is ignored.
    set_len(16'd4);
    bus.x0_i             = 16'hFFFD;
    bus.x0z_i            = 16'd7;
    bus.trigger_vector_i = 4'b1000;
    for (int i = 1; i <= 4; i++) begin
      step();
      if (i == 1) begin
        bus.trigger_vector_i = 4'b0000;
        set_len(16'd9);
      end
      check($sformatf("winC_y0_%0d", i), 64'({bus.y0_o, bus.y0z_o}), 64'hFFFD_0007);
    end
    check("winC_status", bus.user_register_o, st(4, 2, 16));

    // Back-to-back: trigger on the edge right after the final window edge.
    set_len(16'd2);
    bus.x0_i             = 16'd1000;
    bus.x0z_i            = 16'd2000;
    bus.trigger_vector_i = 4'b0010;
    step();
    bus.trigger_vector_i = 4'b0000;
    check("b2b_y0_1", 64'({bus.y0_o, bus.y0z_o}), 64'h03E8_07D0);
    step();
    check("b2b_y0_2",   64'({bus.y0_o, bus.y0z_o}), 64'h03E8_07D0);
    check("b2b_status", bus.user_register_o, st(2, 3, 6000));
    step();
    check("b2b_after_y0", 64'({bus.y0_o, bus.y0z_o}), 64'h0);

    // Held trigger: 40 clocks of 4'b1000 with L=16 gives exactly one window.
    set_len(16'd16);
    bus.x0_i             = 16'd1;
    bus.x0z_i            = 16'd2;
    bus.trigger_vector_i = 4'b1000;
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.y0_o == 16'd1) hits++;
    end
    bus.trigger_vector_i = 4'b0000;
    check("hold_hits",   64'(hits), 64'd16);
    check("hold_status", bus.user_register_o, st(16, 4, 48));

    // L=0: trigger pulses are ignored.
    set_len(16'd0);
    bus.x0_i  = 16'h1234;
    bus.x0z_i = 16'h4321;
    for (int i = 0; i < 8; i++) begin
      bus.trigger_vector_i = (i % 2 == 0) ? 4'b0001 : 4'b0000;
      step();
      check($sformatf("len0_y0_%0d", i), 64'({bus.y0_o, bus.y0z_o}), 64'h0);
    end
    check("len0_status", bus.user_register_o, st(16, 4, 48));

    // L=1: single-cycle window, sum of the trigger-edge pair (-500 + -600).
    bus.trigger_vector_i = 4'b0000;
    set_len(16'd1);
    bus.x0_i  = 16'hFE0C;
    bus.x0z_i = 16'hFDA8;
    step();
    bus.trigger_vector_i = 4'b0100;
    step();
    bus.trigger_vector_i = 4'b0000;
    check("len1_y0", 64'({bus.y0_o, bus.y0z_o}), 64'hFE0C_FDA8);
    step();
    check("len1_after_y0", 64'({bus.y0_o, bus.y0z_o}), 64'h0);
    check("len1_status",   bus.user_register_o, st(1, 5, -1100));

    // Reset at window cycle 8 aborts the window with no status update.
    set_len(16'd16);
    bus.x0_i             = 16'd7;
    bus.x0z_i            = 16'd8;
    bus.trigger_vector_i = 4'b0001;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 1) bus.trigger_vector_i = 4'b0000;
    end
    check("rstwin_y0_pre", 64'({bus.y0_o, bus.y0z_o}), 64'h0007_0008);
    bus.x1_i             = 16'hAAAA;
    bus.x1z_i            = 16'h5555;
    bus.trigger_vector_i = 4'b0110;
    rst_i                = 1'b1;
    step();
    check("rstwin_y0",     64'({bus.y0_o, bus.y0z_o}), 64'h0);
    check("rstwin_status", bus.user_register_o, 64'h0);
    check("rstwin_y1",     64'({bus.y1_o, bus.y1z_o, bus.trigger_vector_o}), 64'h0);
    bus.trigger_vector_i = 4'b0000;
    rst_i                = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("rstwin_post_y0_%0d", i), 64'({bus.y0_o, bus.y0z_o}), 64'h0);
    end
    check("rstwin_post_status", bus.user_register_o, 64'h0);

    // Random pass-through traffic; part numbers stay constant.
    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rt = 4'($urandom);
      bus.x1_i             = ra;
      bus.x1z_i            = rb;
      bus.trigger_vector_i = rt;
      step();
      check($sformatf("pass_%0d", i), 64'({bus.y1_o, bus.y1z_o, bus.trigger_vector_o}),
            64'({ra, rb, rt}));
      check($sformatf("partnum_%0d", i),
            {ul_partnum_1_o, ul_partnum_2_o, ul_partnum_3_o, ul_partnum_rev_o},
            64'h4C44_5350_0001_0100);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
